kbd_scan_bridge: RTL
====================

Name: kbd_scan_bridge

Overview:
Parametrised successor to the keyboard controller. Accepts keyboard scan-code bytes on a one-cycle read strobe and buffers them in a DEPTH-entry FIFO. Forwards them one at a time to the UART transmitter over a write/busy handshake. Adds an optional break/extended-code filter, FIFO occupancy and sticky overflow reporting, and a handshake acknowledge timeout.

Parameters:
DATA_W, 8, scan-code / tx byte width (filter codes compare on low 8 bits)
DEPTH, 8, FIFO entries; power of two, >= 2
ACK_TIMEOUT, 15, cycles to wait for busy to rise after a write pulse before abandoning the byte
FILTER_BREAK, 1, 1 = drop release sequences and E0 prefixes; 0 = forward every byte unchanged

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
read  in  1  one-cycle strobe: rx_data valid
rx_data  in  DATA_W  received scan code
busy  in  1  UART transmitter busy
write  out  1  one-cycle strobe: tx_data valid, start transmit
tx_data  out  DATA_W  byte to transmit
fifo_count  out  $clog2(DEPTH+1)  current FIFO occupancy
overflow  out  1  sticky: a byte was dropped because the FIFO was full

Behaviour:
- Reset (async, active-high): write=0, tx_data=0, fifo_count=0, overflow=0, FIFO pointers=0, break_pending=0, FSM=IDLE, timeout counter=0. Reset mid-transfer abandons the byte and empties the FIFO; no write pulse in the cycle reset deasserts.
- Ingress (sampled on the clk edge where read=1):
  - FILTER_BREAK=0: every byte is pushed.
  - FILTER_BREAK=1:
    - 0xF0: not pushed; sets break_pending.
    - 0xE0: not pushed; break_pending unchanged.
    - Any other byte with break_pending=1: not pushed; clears break_pending.
    - Any other byte with break_pending=0: pushed.
  - Net effect: E0 xx -> xx; F0 xx -> nothing; E0 F0 xx -> nothing.
- FIFO:
  - Push to a full FIFO with no pop on the same edge: byte discarded, overflow<=1, held until reset.
  - Push and pop on the same edge when full: both succeed; count unchanged; overflow not set.
  - Push when empty: count becomes 1 on the next edge.
  - Pointers wrap modulo DEPTH.
  - fifo_count is registered and exact.
- Egress FSM:
  - IDLE: if FIFO non-empty and busy=0, pop the head into tx_data, write<=1, go to STROBE.
  - STROBE: write<=0 (write is high for exactly one cycle); timer<=0; go to WAIT_ACK.
  - WAIT_ACK:
    - busy=1 -> WAIT_DONE.
    - Otherwise timer increments. At timer==ACK_TIMEOUT-1 with busy still 0 -> IDLE; the byte is considered lost and is not re-sent.
  - WAIT_DONE: busy=0 -> IDLE.
- tx_data changes only on the edge that asserts write; it holds between writes.
- Latency: byte sampled with read on edge E into an empty FIFO with busy=0 -> write=1 after edge E+2, for one cycle. Back-to-back bytes are spaced by at least 4 cycles plus the UART busy time.
- If busy=1 in IDLE, nothing is issued; the FIFO keeps filling.
- read arriving in any FSM state is accepted; ingress and egress are independent.

Test Plan:
1. Reset, FILTER_BREAK=1, busy=0; read 0x3A for one cycle -> write=1 for exactly one cycle two edges later, tx_data=0x3A; fifo_count goes 0->1->0; overflow=0.
2. FILTER_BREAK=1; bytes 0x1C, 0xF0, 0x1C, 0xE0, 0x75, 0xE0, 0xF0, 0x75 -> exactly two writes: 0x1C then 0x75. The same sequence with FILTER_BREAK=0 -> eight writes in input order.
3. DEPTH=4, busy held 1; six read strobes 0x01..0x06 -> fifo_count=4, overflow=1. Release busy with a model UART (busy high 10 cycles after each write) -> tx order 0x01..0x04; overflow stays 1.
4. Full FIFO (DEPTH=4) with the FSM popping on the same edge a new read arrives -> count stays 4, overflow stays 0, no byte lost.
5. UART model never raises busy; ACK_TIMEOUT=15; push 0xFA, 0x3B -> write for 0xFA, then write for 0x3B exactly 17 cycles later (STROBE + 15 WAIT_ACK + IDLE).
6. Assert reset while in WAIT_DONE with 3 bytes queued -> write=0, fifo_count=0, overflow=0 immediately (async); no writes after release until new reads arrive.

Source files
------------

// File: rtl/kbd_scan_bridge.sv
// Keyboard scan-code to UART bridge: optional break/extended-code filter,
// DEPTH-entry FIFO with overflow flag, and a write/busy egress handshake with ack timeout.
module kbd_scan_bridge #(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 8,
    parameter int ACK_TIMEOUT  = 15,
    parameter int FILTER_BREAK = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       read,
    input  logic [DATA_W-1:0]          rx_data,
    input  logic                       busy,
    output logic                       write,
    output logic [DATA_W-1:0]          tx_data,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, STROBE, WAIT_ACK, WAIT_DONE} state_t;

    logic              accept;
    logic              push_valid_reg;
    logic [DATA_W-1:0] push_data_reg;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic              overflow_reg;
    logic              full, empty, push_ok, pop;
    state_t            state_reg, state_next;
    logic [TW-1:0]     timer_reg, timer_next;
    logic              write_reg, write_next;
    logic [DATA_W-1:0] tx_data_reg;

    generate
        if (FILTER_BREAK != 0) begin : g_filter
            logic break_pending_reg;
            logic is_break, is_ext;
            assign is_break = (rx_data[7:0] == 8'hF0);
            assign is_ext   = (rx_data[7:0] == 8'hE0);
            assign accept   = !is_break && !is_ext && !break_pending_reg;
            // E0 leaves the pending flag alone so E0 F0 xx is swallowed as a whole.
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    break_pending_reg <= 1'b0;
                else if (read && !is_ext)
                    break_pending_reg <= is_break;
            end
        end else begin : g_pass
            assign accept = 1'b1;
        end
    endgenerate

    // Registered ingress stage; gives the two-edge read-to-write latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            push_valid_reg <= 1'b0;
            push_data_reg  <= '0;
        end else begin
            push_valid_reg <= read && accept;
            if (read)
                push_data_reg <= rx_data;
        end
    end

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push_valid_reg && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= push_data_reg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            tx_data_reg  <= '0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop) begin
                rd_ptr_reg  <= rd_ptr_reg + AW'(1);
                tx_data_reg <= mem[rd_ptr_reg];
            end
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            if (push_valid_reg && full && !pop)
                overflow_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            timer_reg <= '0;
            write_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            write_reg <= write_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        write_next = 1'b0;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!empty && !busy) begin
                    pop        = 1'b1;
                    write_next = 1'b1;
                    state_next = STROBE;
                end
            end
            STROBE: begin
                timer_next = '0;
                state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                // A byte the UART never acknowledges is dropped, not retried.
                if (busy)
                    state_next = WAIT_DONE;
                else if (timer_reg == TW'(ACK_TIMEOUT-1))
                    state_next = IDLE;
                else
                    timer_next = timer_reg + TW'(1);
            end
            WAIT_DONE: begin
                if (!busy)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign write      = write_reg;
    assign tx_data    = tx_data_reg;
    assign fifo_count = count_reg;
    assign overflow   = overflow_reg;
endmodule
